// File: rtl/instr_mem_pkg.sv
// Shared constants for the instruction-fetch responder: state encoding, NOP word,
// wait-counter width and the word-index width helper.
package instr_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int unsigned WS_CNT_W = 4;

    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Word store behind the fetch responder: synchronous write, combinational read, so a read
// and a write to the same word on one edge return the old contents.
module imem_ram
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned IW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: one outstanding valid/ready request, fixed wait-state latency,
// registered response word, plus a write-only load port into the backing store.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_instr_o,
    output logic        rsp_err_o,
    input  logic        load_en_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
);

    localparam int unsigned IW = idx_width(DEPTH);
    localparam logic [WS_CNT_W-1:0] WS_LOAD =
        (WAIT_STATES > 0) ? WS_CNT_W'(WAIT_STATES - 1) : '0;

    logic [1:0]          state, state_next;
    logic [WS_CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic [31:0]         addr_lat;
    logic [31:0]         fetch_addr;
    logic [31:0]         ram_rdata;
    logic [31:0]         rsp_instr;
    logic                rsp_err;
    logic                accept;
    logic                enter_resp;
    logic                fetch_err;
    logic                load_ok;
    logic                unused_load_bits;

    assign req_ready_o = rst_i & (state == ST_IDLE);
    assign accept      = req_valid_i & req_ready_o;

    // With zero wait states RESP is entered on the accept edge, before addr_lat is loaded.
    assign fetch_addr = (state == ST_IDLE) ? req_addr_i : addr_lat;
    assign fetch_err  = (fetch_addr[1:0] != 2'b00) | (fetch_addr[31:IW+2] != '0);

    assign load_ok          = load_en_i & (load_addr_i[31:IW+2] == '0);
    assign unused_load_bits = ^load_addr_i[1:0];

    imem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk_i),
        .wr_en   (load_ok),
        .wr_idx  (load_addr_i[IW+1:2]),
        .wr_data (load_data_i),
        .rd_idx  (fetch_addr[IW+1:2]),
        .rd_data (ram_rdata)
    );

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        enter_resp    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt - WS_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            addr_lat  <= '0;
            rsp_instr <= NOP_INSTR;
            rsp_err   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                addr_lat <= req_addr_i;
            end
            if (enter_resp) begin
                rsp_err   <= fetch_err;
                rsp_instr <= fetch_err ? NOP_INSTR : ram_rdata;
            end
        end
    end

    assign rsp_valid_o = (state == ST_RESP);
    assign rsp_instr_o = rsp_instr;
    assign rsp_err_o   = rsp_err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: a 2-wait-state and a 0-wait-state instance share
// the load port; expected responses come from a word-array model of the program store.
module tb_instr_mem_responder;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned WS    = 2;
    localparam int unsigned WS0   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic        req_valid, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] req_addr, rsp_instr;
    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] req_addr0, rsp_instr0;

    logic [31:0] model_mem [DEPTH];
    exp_t        sb[$];
    exp_t        sb0[$];
    exp_t        e, e0;
    bit          resp_open, resp_open0;
    logic [31:0] held_instr, held_instr0;
    logic        held_err, held_err0;
    bit          rand_stall = 1'b0;
    bit          ready_level = 1'b1;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rsp_ready = rand_stall ? ($urandom_range(0, 2) != 0) : ready_level;
    end

    instr_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_instr_o (rsp_instr),
        .rsp_err_o   (rsp_err),
        .load_en_i   (load_en),
        .load_addr_i (load_addr),
        .load_data_i (load_data)
    );

    instr_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid0),
        .req_ready_o (req_ready0),
        .req_addr_i  (req_addr0),
        .rsp_valid_o (rsp_valid0),
        .rsp_ready_i (rsp_ready0),
        .rsp_instr_o (rsp_instr0),
        .rsp_err_o   (rsp_err0),
        .load_en_i   (load_en),
        .load_addr_i (load_addr),
        .load_data_i (load_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the word at addr/4 if word-aligned and inside the store, else an error NOP.
    function automatic exp_t model_fetch(input logic [31:0] addr, input int unsigned c);
        exp_t r;
        r.cyc = c;
        if ((addr % 4) != 0 || addr >= 32'(4 * DEPTH)) begin
            r.err   = 1'b1;
            r.instr = 32'h0;
        end else begin
            r.err   = 1'b0;
            r.instr = model_mem[int'(addr / 4)];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            resp_open = 1'b0;
        end else if (rsp_valid) begin
            if (!resp_open) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc, e.cyc + WS + 1);
                    check("instr", rsp_instr, e.instr);
                    check("err", 32'(rsp_err), 32'(e.err));
                end
                held_instr = rsp_instr;
                held_err   = rsp_err;
                resp_open  = 1'b1;
            end else begin
                check("hold_instr", rsp_instr, held_instr);
                check("hold_err", 32'(rsp_err), 32'(held_err));
            end
            check("ready_busy", 32'(req_ready), 32'h0);
            if (rsp_ready) resp_open = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            sb0.delete();
            resp_open0 = 1'b0;
        end else if (rsp_valid0) begin
            if (!resp_open0) begin
                if (sb0.size() == 0) begin
                    check("unexpected_rsp0", 32'(rsp_valid0), 32'h0);
                end else begin
                    e0 = sb0.pop_front();
                    check("latency0", cyc, e0.cyc + WS0 + 1);
                    check("instr0", rsp_instr0, e0.instr);
                    check("err0", 32'(rsp_err0), 32'(e0.err));
                end
                held_instr0 = rsp_instr0;
                held_err0   = rsp_err0;
                resp_open0  = 1'b1;
            end else begin
                check("hold_instr0", rsp_instr0, held_instr0);
                check("hold_err0", 32'(rsp_err0), 32'(held_err0));
            end
            check("ready_busy0", 32'(req_ready0), 32'h0);
            if (rsp_ready0) resp_open0 = 1'b0;
        end
    end

    task automatic load_raw(input logic [31:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        if (addr < 32'(4 * DEPTH)) model_mem[int'(addr / 4)] = data;
    endtask

    task automatic fetch(input logic [31:0] addr);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                sb.push_back(model_fetch(addr, cyc));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        req_addr  = $urandom;
        if (!done) check("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic fetch0(input logic [31:0] addr);
        bit done = 1'b0;
        req_valid0 = 1'b1;
        req_addr0  = addr;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (req_ready0) begin
                sb0.push_back(model_fetch(addr, cyc));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid0 = 1'b0;
        req_addr0  = $urandom;
        if (!done) check("accept_timeout0", 32'h0, 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || resp_open || sb0.size() != 0 || resp_open0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (n >= 200) check("drain_timeout", 32'(n), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_valid0 = 1'b0;
        req_addr0  = '0;
        rsp_ready0 = 1'b1;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_instr", rsp_instr, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_req_ready0", 32'(req_ready0), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'h1);
        check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < int'(DEPTH); i++)
            load_raw((32'(i) << 2) | 32'($urandom_range(0, 3)), $urandom);
        load_raw(32'h0, 32'h2001_0005);
        load_raw(32'h4, 32'h2002_000A);
        load_raw(32'h8, 32'h0022_1820);
        load_raw(32'hC, 32'h1000_FFFF);
        load_raw(32'(4 * DEPTH), 32'hBAD0_0000);

        fetch(32'h0);
        drain();
        fetch(32'h8);
        fetch(32'hC);
        fetch(32'h6);
        fetch(32'h200);
        drain();

        // Load word 1 on the edge that enters RESP: the response must carry the old word.
        fetch(32'h4);
        repeat (WS - 1) @(posedge clk);
        #1;
        load_en   = 1'b1;
        load_addr = 32'h4;
        load_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        load_en     = 1'b0;
        model_mem[1] = 32'hDEAD_BEEF;
        drain();
        fetch(32'h4);
        drain();

        rsp_ready0 = 1'b0;
        fetch0(32'h8);
        repeat (4) begin
            @(negedge clk);
            check("stall_valid0", 32'(rsp_valid0), 32'h1);
        end
        @(posedge clk);
        #1;
        rsp_ready0 = 1'b1;
        drain();
        fetch0(32'hC);
        fetch0(32'h7);
        drain();

        fetch(32'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_ready", 32'(req_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            check("abort_no_rsp", 32'(rsp_valid), 32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        rand_stall = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 5) == 0) a = $urandom;
                else a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                fetch(a);
            end
        end
        rand_stall = 1'b0;
        drain();
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
